gate_nand_bist: RTL and testbench

GATE_NAND_BIST -- requirements
Module: gate_nand_bist

---
 rtl/gate_bist_pkg.sv | 13 +
 rtl/gate_nand_ref.sv | 12 +
 rtl/gate_nand_bist.sv | 168 ++++++++++++++++
 tb/tb_gate_nand_bist.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the NAND gate built-in self-test.
package gate_bist_pkg;

  localparam int unsigned ERR_W = 16;
  localparam int unsigned N_MAX = 8;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} bist_state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/gate_nand_ref.sv
// Combinational golden model of the N-bit NAND gate under test.
module gate_nand_ref #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] exp_o
);

  assign exp_o = ~(a_i & b_i);

endmodule

// File: rtl/gate_nand_bist.sv
// Exhaustive BIST controller for an N-bit NAND gate: drives all 4^N operand pairs,
// counts mismatching vectors. Optional first-fail capture via GATE_BIST_FIRST_FAIL_EN.
module gate_nand_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     a_out,
  output logic [N-1:0]     b_out,
  input  logic [N-1:0]     f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef GATE_BIST_FIRST_FAIL_EN
  output logic             fail_valid,
  output logic [N-1:0]     fail_a,
  output logic [N-1:0]     fail_b,
  output logic [N-1:0]     fail_f,
`endif
  output logic [ERR_W-1:0] err_count
);

  if (N < 1 || N > N_MAX) begin : g_bad_width
    $error("gate_nand_bist: N out of range 1..N_MAX");
  end

  bist_state_t          state_q, state_d;
  logic [2*N-1:0]       vec_q, vec_d;
  logic [N-1:0]         a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [N-1:0]         exp_f;
  logic                 mismatch;

  gate_nand_ref #(
    .N (N)
  ) u_ref (
    .a_i   (a_q),
    .b_i   (b_q),
    .exp_o (exp_f)
  );

  assign mismatch = (f_in != exp_f);

`ifdef GATE_BIST_FIRST_FAIL_EN
  logic         fv_q, fv_d;
  logic [N-1:0] fa_q, fa_d, fb_q, fb_d, ff_q, ff_d;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
`ifdef GATE_BIST_FIRST_FAIL_EN
    fv_d = fv_q;
    fa_d = fa_q;
    fb_d = fb_q;
    ff_d = ff_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = DRIVE;
`ifdef GATE_BIST_FIRST_FAIL_EN
          fv_d = 1'b0;
          fa_d = '0;
          fb_d = '0;
          ff_d = '0;
`endif
        end
      end
      DRIVE: begin
        a_d     = vec_q[2*N-1:N];
        b_d     = vec_q[N-1:0];
        state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = sat_inc(err_q);
`ifdef GATE_BIST_FIRST_FAIL_EN
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
            ff_d = f_in;
          end
`endif
        end
        if (&vec_q) begin
          // Verdict uses the count that already includes this last vector.
          pass_d  = (err_d == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          vec_d   = vec_q + (2*N)'(1);
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef GATE_BIST_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q <= 1'b0;
      fa_q <= '0;
      fb_q <= '0;
      ff_q <= '0;
    end else begin
      fv_q <= fv_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
      ff_q <= ff_d;
    end
  end

  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
  assign fail_f     = ff_q;
`endif

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign err_count = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_gate_nand_bist.sv
// Directed bench for gate_nand_bist (N=4) with a scoreboard of expected run results.
module tb_gate_nand_bist;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a_out, b_out, f_in;
  logic         busy, done, pass;
  logic [15:0]  err_count;
  int           mode = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

`ifdef GATE_BIST_FIRST_FAIL_EN
  logic         fail_valid;
  logic [N-1:0] fail_a, fail_b, fail_f;
`endif

  typedef struct {
    int   err;
    logic pass;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Gate under test: 0 = good NAND, 1 = bit 0 stuck at 0, 2 = AND gate.
  always_comb begin
    f_in = ~(a_out & b_out);
    if (mode == 1) f_in = ~(a_out & b_out) & 4'b1110;
    else if (mode == 2) f_in = a_out & b_out;
  end

  gate_nand_bist #(
    .N (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_out      (a_out),
    .b_out      (b_out),
    .f_in       (f_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
`ifdef GATE_BIST_FIRST_FAIL_EN
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_f     (fail_f),
`endif
    .err_count  (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int m, input bit hold, input int exp_err);
    exp_t e;
    exp_t got_e;
    int   edges;
    e.err  = exp_err;
    e.pass = (exp_err == 0);
    sb.push_back(e);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("err_cleared", {16'b0, err_count}, 32'd0);
    edges = 0;
    for (int k = 1; k <= 600 && edges == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) edges = k;
    end
    chk("done_edge", edges, 32'd512);
    got_e = sb.pop_front();
    chk("err_count", {16'b0, err_count}, got_e.err);
    chk("pass", {31'b0, pass}, {31'b0, got_e.pass});
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    chk("last_vector", {24'b0, a_out, b_out}, 32'hFF);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart", {31'b0, busy}, 32'd0);
    chk("err_hold", {16'b0, err_count}, got_e.err);
    chk("pass_hold", {31'b0, pass}, {31'b0, got_e.pass});
  endtask

  initial begin
    int bad_cnt;
    #1;
    chk("rst_outputs", {busy, done, pass, err_count, a_out, b_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start", {busy, done, pass, err_count}, 32'd0);

    run(0, 1'b0, 0);
    run(1, 1'b0, 192);
`ifdef GATE_BIST_FIRST_FAIL_EN
    chk("fail_valid", {31'b0, fail_valid}, 32'd1);
    chk("fail_abf", {20'b0, fail_a, fail_b, fail_f}, 32'h00E);
`endif
    run(2, 1'b0, 256);
    run(0, 1'b1, 0);
`ifdef GATE_BIST_FIRST_FAIL_EN
    chk("fail_cleared", {19'b0, fail_valid, fail_a, fail_b, fail_f}, 32'd0);
`endif

    // Abort a run at edge 100 with an asynchronous reset.
    mode  = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    chk("busy_mid_run", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", {busy, done, pass, err_count, a_out, b_out}, 32'd0);
    bad_cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad_cnt++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad_cnt++;
    end
    chk("no_done_no_run_after_rst", bad_cnt, 32'd0);

    run(1, 1'b0, 192);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
